// File: rtl/mem_access_unit.sv
// Load/store initiator between execute and data memory; 2-3 cycles per request (4 for sub-word RMW stores).
// Backpressure: req_ready is high only in IDLE, so one request is in flight at a time with no queuing.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ce,
  output logic        mem_we,
  output logic        mem_memRr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wtData,
  output logic [3:0]  mem_w_mask,
  output logic [3:0]  mem_r_mask,
  input  logic [31:0] mem_rdData
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, signed_q, err_q, rmw_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, data_q;

  logic        accept, req_err, req_rmw;
  logic [4:0]  lane_sh;
  logic [31:0] lane_mask, merged, load_val;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign accept  = req_valid && (state_q == S_IDLE);
  assign req_err = (req_size == 2'd3) ||
                   ((req_size == 2'd1) && req_addr[0]) ||
                   ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  // Memory writes only low lanes, so sub-word stores at a non-zero offset need a read first
  assign req_rmw = req_we && !req_err && (req_size != 2'd2) && (req_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      rmw_q    <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      data_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        err_q    <= req_err;
        rmw_q    <= req_rmw;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if ((state_q == S_LOAD) || (state_q == S_RMW_RD)) begin
        data_q <= mem_rdData;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)      state_d = S_RESP;
          else if (!req_we) state_d = S_LOAD;
          else if (req_rmw) state_d = S_RMW_RD;
          else              state_d = S_WRITE;
        end
      end
      S_LOAD:   state_d = S_RESP;
      S_RMW_RD: state_d = S_WRITE;
      S_WRITE:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Lane extraction and merge work from the captured word and the latched offset
  always_comb begin
    lane_sh   = {addr_q[1:0], 3'b000};
    lane_mask = (size_q == 2'd0) ? (32'h0000_00FF << lane_sh) : (32'h0000_FFFF << lane_sh);
    merged    = (size_q == 2'd0) ?
                ((data_q & ~lane_mask) | ({24'd0, wdata_q[7:0]} << lane_sh)) :
                ((data_q & ~lane_mask) | ({16'd0, wdata_q[15:0]} << lane_sh));
    case (addr_q[1:0])
      2'd0:    load_byte = data_q[7:0];
      2'd1:    load_byte = data_q[15:8];
      2'd2:    load_byte = data_q[23:16];
      default: load_byte = data_q[31:24];
    endcase
    load_half = addr_q[1] ? data_q[31:16] : data_q[15:0];
    case (size_q)
      2'd0:    load_val = {{24{signed_q & load_byte[7]}}, load_byte};
      2'd1:    load_val = {{16{signed_q & load_half[15]}}, load_half};
      default: load_val = data_q;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_ce     = 1'b0;
    mem_we     = 1'b0;
    mem_memRr  = 1'b0;
    mem_addr   = 32'd0;
    mem_wtData = 32'd0;
    mem_w_mask = 4'b0000;
    mem_r_mask = 4'b0000;
    case (state_q)
      S_LOAD, S_RMW_RD: begin
        mem_ce     = 1'b1;
        mem_memRr  = 1'b1;
        mem_r_mask = 4'b1111;
        mem_addr   = {addr_q[31:2], 2'b00};
      end
      S_WRITE: begin
        mem_ce   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
        if (rmw_q) begin
          mem_wtData = merged;
          mem_w_mask = 4'b1111;
        end else begin
          mem_wtData = wdata_q;
          case (size_q)
            2'd0:    mem_w_mask = 4'b0001;
            2'd1:    mem_w_mask = 4'b0011;
            default: mem_w_mask = 4'b1111;
          endcase
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? 32'd0 : load_val;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator sitting between the execute stage and the data memory. Accepts one byte/half/word load or store per handshake, drives the memory's chip-enable, read/write enables, masks and address, and returns extracted, sign/zero-extended load data. Because the memory only supports low-lane sub-word access (mask 0001 / 0011), sub-word stores at non-zero byte offsets are done as a read-modify-write of the full word. Misaligned halfword/word accesses are rejected without touching memory.

## Interface
- No parameters; widths fixed at 32-bit data and address.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on a rising edge with req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed  in  1  sign-extend loads (ignored for word and stores).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal-size request; valid with resp_valid.
- mem_ce, mem_we, mem_memRr  out  1 each  memory chip enable, write enable, read enable.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_wtData  out  32  write data.
- mem_w_mask, mem_r_mask  out  4  write/read masks.
- mem_rdData  in  32  combinational read data from memory.

## Operation
- Moore FSM: IDLE, LOAD, RMW_RD, WRITE, RESP. All memory outputs decoded from registered state and latched request; 0 in IDLE and RESP.
- IDLE: on accept, latch we/size/signed/addr/wdata. Error if size==3, size==1 && addr[0], size==2 && addr[1:0]!=0 -> RESP with err. Else load -> LOAD; store word, or byte/half with addr[1:0]==0 -> WRITE (direct); other sub-word store -> RMW_RD.
- LOAD / RMW_RD: mem_ce=1, mem_memRr=1, mem_r_mask=4'b1111; mem_rdData captured into data register at end of cycle. LOAD -> RESP, RMW_RD -> WRITE.
- WRITE: mem_ce=1, mem_we=1. Direct: mem_wtData=req_wdata, mask 1111 (word), 0001 (byte), 0011 (half). RMW: mem_wtData = captured word with byte lane addr[1:0] (or half lane addr[1]) replaced by wdata[7:0]/[15:0], mask 1111. -> RESP.
- Load extraction: byte = word[8*addr[1:0]+:8], half = word[16*addr[1]+:16]; extend per req_signed; word passes through.
- RESP: resp_valid=1, resp_rdata/resp_err from registers; -> IDLE.
- req_* inputs ignored outside IDLE; no queuing.

## Timing
- Reset (asynchronous, immediate): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all mem_* outputs 0, internal registers 0.
- Accept at edge T. Load: LOAD in cycle T+1, resp_valid in T+2. Direct store: WRITE T+1 (memory updates at its closing edge), resp T+2. RMW store: RMW_RD T+1, WRITE T+2, resp T+3. Error: resp T+1, mem_ce never asserted.
- Next accept earliest at the edge ending RESP's successor IDLE cycle; throughput one request per 3/3/4/2 cycles.
- Reset during LOAD/RMW_RD/WRITE: mem_we/mem_ce drop immediately; no write occurs if rst_n falls before the WRITE closing edge; no resp_valid for the aborted request.

## Test plan
- Preload word 0 = 0xAEB1C2AA. Load byte signed @0x1 -> resp_rdata 0xFFFFFFC2 at T+2; unsigned byte @0x3 -> 0x000000AE; mem_r_mask 1111, mem_addr 0x0 during LOAD.
- Half signed @0x2 -> 0xFFFFAEB1; half @0x1 -> resp_err=1, resp_rdata 0 at T+1, mem_ce low throughout; size 3 @0x0 -> resp_err=1.
- Store byte 0x55 @0x2 -> RMW_RD T+1, WRITE T+2 with mem_wtData 0xAE55C2AA mask 1111, resp T+3; reread word -> 0xAE55C2AA.
- Store byte 0x11 @0x0 -> single WRITE, mask 0001, resp T+2; word becomes 0xAEB1C211. Store half 0xBEEF @0x0 -> mask 0011, word 0xAEB1BEEF.
- Hold req_valid high with back-to-back load/store: req_ready low from T+1 until IDLE; each request gets exactly one resp_valid, in order.
- Assert rst_n low mid-WRITE of RMW store -> mem_we drops same cycle, memory word unchanged, outputs at reset values, next request serviced normally.
